// File: rtl/ntt_sdf_pkg.sv
// Shared constants and types for the 16-point radix-2 SDF NTT control path.
package ntt_sdf_pkg;

  localparam int N         = 16;
  localparam int LOG2N     = 4;
  localparam int STAGES    = 4;
  localparam int TRK_DEPTH = N - 1;

  localparam int D_K   [STAGES] = '{8, 4, 2, 1};
  localparam int OFF_K [STAGES] = '{0, 8, 12, 14};

  typedef logic [LOG2N-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Sample position as seen by a stage that starts OFF samples after stage 1.
  function automatic cnt_t local_cnt(input cnt_t cnt, input int off);
    return cnt - cnt_t'(off);
  endfunction

endpackage

// File: rtl/sdf_valid_tracker.sv
// Shift register that follows a per-sample flag through the SDF pipeline.
module sdf_valid_tracker
  import ntt_sdf_pkg::*;
#(
  parameter int DEPTH = TRK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [DEPTH-1:0] q_o
);

  logic [DEPTH-1:0] trk_q, trk_d;

  always_comb begin
    trk_d = trk_q;
    if (shift_en_i) trk_d = {trk_q[DEPTH-2:0], bit_i};
  end

  always_ff @(posedge clk) begin
    if (rst) trk_q <= '0;
    else     trk_q <= trk_d;
  end

  assign q_o = trk_q;

endmodule

// File: rtl/ntt_sdf_sequencer.sv
// Control sequencer for a four-stage 16-point SDF NTT: advance gating,
// per-stage butterfly/twiddle selects and output valid/last tracking.
module ntt_sdf_sequencer
  import ntt_sdf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       pipe_en,
  output logic [3:0] bf_mode,
  output logic       tw_sel_s2,
  output logic [1:0] tw_sel_s3,
  output logic [2:0] tw_sel_s4,
  output logic       out_valid,
  output logic       out_last,
  output logic       done_tick,
  output logic       busy
);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   accept, adv, last_in;
  logic [TRK_DEPTH-1:0] vld_q, last_q;
  cnt_t   lc [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A drain ends once the sample leaving on this advance is the last one in flight.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_RUN;
        S_RUN:   if (!in_valid && cnt_q == '0) state_d = S_DRAIN;
        S_DRAIN: begin
          if (accept)                           state_d = S_RUN;
          else if (vld_q[TRK_DEPTH-2:0] == '0)  state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = enable & ~rst;
    accept   = in_valid & in_ready;
    adv      = in_ready & (in_valid | (state_q == S_DRAIN));
    busy     = (state_q != S_IDLE);
    cnt_d    = adv ? cnt_q + cnt_t'(1) : cnt_q;
    last_in  = accept & (cnt_q == cnt_t'(N - 1));
  end

  assign pipe_en = adv;

  sdf_valid_tracker #(.DEPTH(TRK_DEPTH)) u_vld_trk (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (adv),
    .bit_i      (accept),
    .q_o        (vld_q)
  );

  sdf_valid_tracker #(.DEPTH(TRK_DEPTH)) u_last_trk (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (adv),
    .bit_i      (last_in),
    .q_o        (last_q)
  );

  assign out_valid = vld_q[TRK_DEPTH-1] & adv;
  assign out_last  = last_q[TRK_DEPTH-1] & adv;
  assign done_tick = out_valid & out_last;

  // Stage k sits in its butterfly phase when bit log2(D_k) of its local count is set.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LD = $clog2(D_K[k]);
    assign lc[k]      = local_cnt(cnt_q, OFF_K[k]);
    assign bf_mode[k] = lc[k][LD];
  end

  assign tw_sel_s2 = lc[1][3];
  assign tw_sel_s3 = lc[2][3:2];
  assign tw_sel_s4 = lc[3][3:1];

  logic unused_bits;
  assign unused_bits = ^{lc[0][2:0], lc[2][0], last_q[TRK_DEPTH-2:0]};

endmodule

// File: tb/tb_ntt_sdf_sequencer.sv
// Directed bench for ntt_sdf_sequencer with a scoreboard of in-flight samples.
module tb_ntt_sdf_sequencer;

  logic       clk, rst, enable, in_valid;
  logic       in_ready, pipe_en, tw_sel_s2, out_valid, out_last, done_tick, busy;
  logic [3:0] bf_mode;
  logic [1:0] tw_sel_s3;
  logic [2:0] tw_sel_s4;

  ntt_sdf_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pipe_en   (pipe_en),
    .bf_mode   (bf_mode),
    .tw_sel_s2 (tw_sel_s2),
    .tw_sel_s3 (tw_sel_s3),
    .tw_sel_s4 (tw_sel_s4),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done_tick (done_tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int exit_adv;
    bit last;
  } sb_t;

  sb_t sb[$];
  int  done_at[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  m_state  = 0;  // 0 idle, 1 run, 2 drain
  int  m_cnt    = 0;
  int  m_adv    = 0;
  int  cyc_n    = 0;
  int  n_out, n_done, first_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lcnt(input int off);
    return (m_cnt + 16 - off) % 16;
  endfunction

  task automatic clear_tally();
    n_out = 0;
    n_done = 0;
    first_out = -1;
    done_at.delete();
  endtask

  task automatic cyc(input logic v, input logic e, input logic r);
    logic e_rdy, e_acc, e_adv, e_ov, e_ol;
    logic [3:0] e_bf;
    int pre_cnt;
    int off_t[4];
    int ld_t[4];
    off_t = '{0, 8, 12, 14};
    ld_t  = '{3, 2, 1, 0};
    @(negedge clk);
    in_valid = v;
    enable   = e;
    rst      = r;
    #1;
    e_rdy = e & ~r;
    e_acc = v & e_rdy;
    e_adv = e_rdy & (v | (m_state == 2));
    e_ov  = 1'b0;
    e_ol  = 1'b0;
    if (e_adv && sb.size() > 0 && sb[0].exit_adv == m_adv) begin
      e_ov = 1'b1;
      e_ol = sb[0].last;
    end
    for (int k = 0; k < 4; k++) e_bf[k] = 1'((lcnt(off_t[k]) >> ld_t[k]) & 1);
    chk("in_ready",  in_ready,  e_rdy);
    chk("pipe_en",   pipe_en,   e_adv);
    chk("out_valid", out_valid, e_ov);
    chk("out_last",  out_last,  e_ol);
    chk("done_tick", done_tick, e_ov & e_ol);
    chk("busy",      busy,      m_state != 0);
    chk("bf_mode",   bf_mode,   e_bf);
    chk("tw_sel_s2", tw_sel_s2, lcnt(8) >> 3);
    chk("tw_sel_s3", tw_sel_s3, lcnt(12) >> 2);
    chk("tw_sel_s4", tw_sel_s4, lcnt(14) >> 1);
    if (out_valid === 1'b1) begin
      n_out++;
      if (first_out < 0) first_out = cyc_n;
    end
    if (done_tick === 1'b1) begin
      n_done++;
      done_at.push_back(cyc_n);
    end
    pre_cnt = m_cnt;
    if (r) begin
      m_state = 0;
      m_cnt   = 0;
      sb.delete();
    end else if (e) begin
      if (e_ov) void'(sb.pop_front());
      if (e_acc) sb.push_back('{exit_adv: m_adv + 15, last: (pre_cnt == 15)});
      if (e_adv) begin
        m_cnt = (m_cnt + 1) % 16;
        m_adv++;
      end
      case (m_state)
        0: if (e_acc) m_state = 1;
        1: if (!v && pre_cnt == 0) m_state = 2;
        default: begin
          if (e_acc) m_state = 1;
          else if (sb.size() == 0) m_state = 0;
        end
      endcase
    end
    cyc_n++;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while (m_state != 0 && k < 40) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b1, 1'b0);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b1);
    clear_tally();
  endtask

  initial begin
    int t0, k;
    rst = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    clear_tally();

    // Reset state
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bf_mode", bf_mode, 4'd0);
    chk("rst_tw_s2", tw_sel_s2, 1'b1);
    chk("rst_tw_s3", tw_sel_s3, 2'd1);
    chk("rst_tw_s4", tw_sel_s4, 3'd1);
    chk("rst_pipe_en", pipe_en, 1'b0);

    // One frame then drain
    clear_tally();
    t0 = cyc_n;
    feed(16);
    drain();
    chk("f1_outs", n_out, 16);
    chk("f1_done", n_done, 1);
    chk("f1_first", first_out - t0, 15);

    // Three back-to-back frames
    do_reset();
    feed(48);
    drain();
    chk("f3_outs", n_out, 48);
    chk("f3_done", n_done, 3);
    chk("f3_space", done_at.size() >= 2 ? done_at[1] - done_at[0] : -1, 16);

    // Mid-frame gap of 5 cycles after sample 7
    do_reset();
    t0 = cyc_n;
    feed(7);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("gap_pipe_en", pipe_en, 1'b0);
    end
    feed(9);
    drain();
    chk("gap_first", first_out - t0, 20);
    chk("gap_outs", n_out, 16);
    chk("gap_done", n_done, 1);

    // enable dropped during drain
    do_reset();
    feed(16);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("hold_out_valid", out_valid, 1'b0);
      chk("hold_done", done_tick, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    drain();
    chk("hold_outs", n_out, 16);
    chk("hold_done_n", n_done, 1);

    // Reset at sample 10, then a clean frame
    do_reset();
    feed(10);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("rst10_busy", busy, 1'b0);
    chk("rst10_out_valid", out_valid, 1'b0);
    clear_tally();
    feed(16);
    drain();
    chk("rst10_outs", n_out, 16);
    chk("rst10_done", n_done, 1);

    // New data arriving during drain resumes RUN in the current slot
    do_reset();
    feed(16);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    do begin
      cyc(1'b1, 1'b1, 1'b0);
      k++;
    end while (m_cnt != 0 && k < 32);
    drain();
    chk("resume_outs", n_out, 16 + k);
    chk("resume_done", n_done, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
